apb4_multi_master: RTL and testbench

//  Next-generation APB master. Buffers requests in a FIFO and drives APB4 transfers (pstrb) to
//  up to NUM_SLAVES slaves, selected by address decode. Times out hung slaves.

---
 rtl/apb4_multi_master.sv | 209 ++++++++++++++++++++
 tb/tb_apb4_multi_master.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_multi_master.sv
// Generic single-clock FIFO used for request buffering.
// Latency: a pushed entry is visible at rd_dat one cycle after the push edge.
// Backpressure: wr_rdy drops when full; rd_vld drops when empty; no fall-through.
module apb4_mm_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             pclk,
    input  logic             preset_n,
    input  logic             wr_vld,
    output logic             wr_rdy,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push;
    logic             pop;

    assign wr_rdy = (count != (PTR_W+1)'(DEPTH));
    assign rd_vld = (count != '0);
    assign push   = wr_vld & wr_rdy;
    assign pop    = rd_vld & rd_rdy;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge pclk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end
endmodule

// Buffered APB4 master: decodes the address to one of NUM_SLAVES and runs one transfer at a time.
// Latency: zero-wait transfer gives done_o 3 cycles after accept; decode error gives it after 2.
// Backpressure: trans_rdy_o drops when the request FIFO is full; hung slaves are aborted by timeout.
module apb4_multi_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             pclk,
    input  logic                             preset_n,
    input  logic                             trans_i,
    output logic                             trans_rdy_o,
    input  logic [ADDR_WIDTH-1:0]            addr_i,
    input  logic [DATA_WIDTH-1:0]            wdata_i,
    input  logic [DATA_WIDTH/8-1:0]          strb_i,
    input  logic                             wr_rd_i,
    output logic [NUM_SLAVES-1:0]            pselx,
    output logic                             penable,
    output logic                             pwrite,
    output logic [ADDR_WIDTH-1:0]            paddr,
    output logic [DATA_WIDTH-1:0]            pwdata,
    output logic [DATA_WIDTH/8-1:0]          pstrb,
    input  logic [NUM_SLAVES-1:0]            pready,
    input  logic [NUM_SLAVES-1:0]            pslverr,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
    output logic                             done_o,
    output logic [DATA_WIDTH-1:0]            rdata_o,
    output logic                             trans_err_o,
    output logic [1:0]                       err_code_o
);
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int SEL_BITS = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [SEL_BITS:0] SEL_LIM  = (SEL_BITS+1)'(NUM_SLAVES);
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef struct packed {
        logic                  wr;
        logic [STRB_W-1:0]     strb;
        logic [DATA_WIDTH-1:0] wdata;
        logic [ADDR_WIDTH-1:0] addr;
    } req_t;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                state_q, state_d;
    req_t                  req_dat, head;
    logic                  head_vld, pop;
    logic [SEL_BITS-1:0]   head_idx, idx_q;
    logic                  head_dec_err, dec_pend_q;
    logic [CNT_W-1:0]      tmo_q;
    logic                  sel_rdy, sel_err, timeout_hit;
    logic [DATA_WIDTH-1:0] sel_rdata;

    assign req_dat = '{wr: wr_rd_i, strb: strb_i, wdata: wdata_i, addr: addr_i};

    apb4_mm_fifo #(.WIDTH($bits(req_t)), .DEPTH(FIFO_DEPTH)) u_req_fifo (
        .pclk     (pclk),
        .preset_n (preset_n),
        .wr_vld   (trans_i),
        .wr_rdy   (trans_rdy_o),
        .wr_dat   (req_dat),
        .rd_vld   (head_vld),
        .rd_rdy   (pop),
        .rd_dat   (head)
    );

    assign head_idx     = head.addr[ADDR_WIDTH-1 -: SEL_BITS];
    assign head_dec_err = ({1'b0, head_idx} >= SEL_LIM);
    assign penable      = (state_q == ACCESS);
    assign timeout_hit  = (TIMEOUT_CYCLES != 0) && !sel_rdy && (tmo_q == TMO_LAST);

    // Only the addressed slave's response lines are looked at.
    always_comb begin
        pselx     = '0;
        sel_rdy   = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (idx_q == SEL_BITS'(k)) begin
                pselx[k]  = (state_q != IDLE);
                sel_rdy   = pready[k];
                sel_err   = pslverr[k];
                sel_rdata = prdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A pending decode error holds off the next pop so its done_o cannot collide with another.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (head_vld && !dec_pend_q) begin
                    pop = 1'b1;
                    if (!head_dec_err) state_d = SETUP;
                end
            end
            SETUP:   state_d = ACCESS;
            ACCESS:  if (sel_rdy || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            dec_pend_q  <= 1'b0;
            tmo_q       <= '0;
            paddr       <= '0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            pstrb       <= '0;
            done_o      <= 1'b0;
            rdata_o     <= '0;
            trans_err_o <= 1'b0;
            err_code_o  <= 2'b00;
        end else begin
            state_q     <= state_d;
            done_o      <= 1'b0;
            trans_err_o <= 1'b0;
            err_code_o  <= 2'b00;
            dec_pend_q  <= pop && head_dec_err;
            if (pop) begin
                paddr  <= head.addr;
                pwrite <= head.wr;
                pwdata <= head.wdata;
                pstrb  <= head.wr ? head.strb : '0;
                idx_q  <= head_idx;
            end
            if (dec_pend_q) begin
                done_o      <= 1'b1;
                trans_err_o <= 1'b1;
                err_code_o  <= 2'b10;
            end
            if (state_q == ACCESS) begin
                if (sel_rdy) begin
                    done_o      <= 1'b1;
                    trans_err_o <= sel_err;
                    err_code_o  <= sel_err ? 2'b01 : 2'b00;
                    if (!pwrite) rdata_o <= sel_rdata;
                    tmo_q       <= '0;
                end else if (timeout_hit) begin
                    done_o      <= 1'b1;
                    trans_err_o <= 1'b1;
                    err_code_o  <= 2'b11;
                    tmo_q       <= '0;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_apb4_multi_master.sv
// Directed bench for apb4_multi_master with a transaction-level response model and per-cycle compare.
module tb_apb4_multi_master;
    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int NS  = 3;
    localparam int FD  = 4;
    localparam int TMO = 16;
    localparam int SW  = DW / 8;

    logic           pclk = 1'b0;
    logic           preset_n = 1'b0;
    logic           trans_i = 1'b0;
    logic           trans_rdy_o;
    logic [AW-1:0]  addr_i = '0;
    logic [DW-1:0]  wdata_i = '0;
    logic [SW-1:0]  strb_i = '0;
    logic           wr_rd_i = 1'b0;
    logic [NS-1:0]  pselx;
    logic           penable;
    logic           pwrite;
    logic [AW-1:0]  paddr;
    logic [DW-1:0]  pwdata;
    logic [SW-1:0]  pstrb;
    logic [NS-1:0]  pready = '0;
    logic [NS-1:0]  pslverr = '0;
    logic [NS*DW-1:0] prdata = '0;
    logic           done_o;
    logic [DW-1:0]  rdata_o;
    logic           trans_err_o;
    logic [1:0]     err_code_o;

    apb4_multi_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS),
        .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .pclk(pclk), .preset_n(preset_n),
        .trans_i(trans_i), .trans_rdy_o(trans_rdy_o),
        .addr_i(addr_i), .wdata_i(wdata_i), .strb_i(strb_i), .wr_rd_i(wr_rd_i),
        .pselx(pselx), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .pslverr(pslverr), .prdata(prdata),
        .done_o(done_o), .rdata_o(rdata_o), .trans_err_o(trans_err_o), .err_code_o(err_code_o)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        logic          wr;
        logic          dec;
        int            idx;
        logic [1:0]    code;
        logic [DW-1:0] rdata;
        int            lat;
        int            psel_n;
        int            pen_n;
        bit            iso;
        int            acc_cyc;
    } exp_t;

    exp_t          q[$];
    int            waits[NS];
    logic          serr[NS];
    logic [DW-1:0] sdata[NS];
    int            acc_cnt[NS];
    int            cyc = 0;
    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] model_rdata = '0;
    int            psel_cyc = 0;
    int            pen_cyc = 0;

    always @(posedge pclk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slave models: selected slave inserts waits[k] wait states; unselected ones drive junk.
    initial begin
        for (int k = 0; k < NS; k++) begin
            waits[k] = 0; serr[k] = 1'b0; sdata[k] = '0; acc_cnt[k] = 0;
        end
        forever begin
            @(negedge pclk);
            for (int k = 0; k < NS; k++) begin
                if (pselx[k] && penable) begin
                    pready[k]  = (acc_cnt[k] >= waits[k]);
                    pslverr[k] = serr[k];
                    prdata[k*DW +: DW] = sdata[k];
                    acc_cnt[k]++;
                end else begin
                    pready[k]  = 1'b1;
                    pslverr[k] = 1'b1;
                    prdata[k*DW +: DW] = 32'hBAD0_0000 | k;
                    acc_cnt[k] = 0;
                end
            end
        end
    end

    // Per-cycle compare against the in-order expected-response queue.
    initial begin
        exp_t          e;
        logic [NS-1:0] oh;
        forever begin
            @(negedge pclk);
            if (!preset_n) begin
                chk("rst_pselx", pselx, 0);
                chk("rst_penable", penable, 0);
                chk("rst_done", done_o, 0);
                chk("rst_rdy", trans_rdy_o, 1);
                chk("rst_err", {trans_err_o, err_code_o}, 0);
                chk("rst_apb_regs", {paddr, pwrite, pstrb}, 0);
                chk("rst_data", {pwdata, rdata_o}, 0);
                q.delete();
                model_rdata = '0;
                psel_cyc = 0;
                pen_cyc = 0;
            end else begin
                if (pselx != '0) begin
                    psel_cyc++;
                    if (q.size() == 0 || q[0].dec) begin
                        chk("psel_unexpected", pselx, 0);
                    end else begin
                        oh = '0;
                        oh[q[0].idx] = 1'b1;
                        chk("pselx", pselx, oh);
                        chk("paddr", paddr, q[0].addr);
                        chk("pwrite", pwrite, q[0].wr);
                        chk("pwdata", pwdata, q[0].wdata);
                        chk("pstrb", pstrb, q[0].wr ? q[0].strb : '0);
                    end
                end
                if (penable) begin
                    pen_cyc++;
                    chk("penable_without_psel", (pselx != '0), 1);
                end
                if (done_o) begin
                    if (q.size() == 0) begin
                        chk("spurious_done", done_o, 0);
                    end else begin
                        e = q.pop_front();
                        chk("trans_err", trans_err_o, (e.code != 2'b00));
                        chk("err_code", err_code_o, e.code);
                        if (!e.wr && e.code <= 2'b01) model_rdata = e.rdata;
                        if (!e.dec) begin
                            chk("psel_cycles", psel_cyc, e.psel_n);
                            chk("penable_cycles", pen_cyc, e.pen_n);
                        end
                        if (e.iso) chk("latency", cyc - e.acc_cyc, e.lat);
                    end
                    psel_cyc = 0;
                    pen_cyc = 0;
                end else begin
                    chk("err_idle", {trans_err_o, err_code_o}, 0);
                end
                chk("rdata_o", rdata_o, model_rdata);
            end
        end
    end

    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                        input logic w, output bit acc);
        exp_t e;
        int   ix;
        @(negedge pclk);
        trans_i = 1'b1; addr_i = a; wdata_i = d; strb_i = s; wr_rd_i = w;
        acc = trans_rdy_o;
        if (acc) begin
            ix = int'(a[AW-1 -: 2]);
            e.addr = a; e.wdata = d; e.strb = s; e.wr = w; e.idx = ix;
            e.dec = (ix >= NS); e.iso = (q.size() == 0); e.acc_cyc = cyc + 1;
            e.rdata = '0; e.psel_n = 0; e.pen_n = 0;
            if (e.dec) begin
                e.code = 2'b10; e.lat = 2;
            end else if (waits[ix] >= TMO) begin
                e.code = 2'b11; e.lat = 2 + TMO; e.psel_n = 1 + TMO; e.pen_n = TMO;
            end else begin
                e.code = serr[ix] ? 2'b01 : 2'b00; e.rdata = sdata[ix];
                e.lat = 3 + waits[ix]; e.psel_n = 2 + waits[ix]; e.pen_n = 1 + waits[ix];
            end
            q.push_back(e);
        end
        @(posedge pclk);
        #1 trans_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge pclk);
            n++;
        end
        chk("drain_outstanding", q.size(), 0);
        q.delete();
        repeat (2) @(negedge pclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, expected finish before 200000 ns");
        $fatal(1);
    end

    initial begin
        bit a;
        bit acc_v[6];
        int n;
        repeat (3) @(negedge pclk);
        chk("reset_rdy", trans_rdy_o, 1);
        #2 preset_n = 1'b1;
        repeat (2) @(negedge pclk);

        // zero-wait write to slave 1
        send(8'h45, 32'hA5A5_0001, 4'hF, 1'b1, a);
        chk("t1_accept", a, 1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge pclk);
            chk("t1_done_timing", done_o, (i == 4));
        end
        chk("t1_err_code", err_code_o, 2'b00);
        drain();

        // read with three wait states on slave 2
        waits[2] = 3; sdata[2] = 32'hDEAD_BEEF;
        send(8'h80, 32'h0, 4'hF, 1'b0, a);
        drain();
        chk("t2_rdata", rdata_o, 32'hDEAD_BEEF);

        // hung slave 0 times out after 16 ACCESS cycles
        waits[0] = 100;
        send(8'h10, 32'h0, 4'h0, 1'b0, a);
        repeat (18) @(negedge pclk);
        @(negedge pclk);
        chk("t3_done", done_o, 1);
        chk("t3_code", err_code_o, 2'b11);
        drain();
        chk("t3_rdata_kept", rdata_o, 32'hDEAD_BEEF);
        waits[0] = 0;

        // decode error on idx 3
        send(8'hC0, 32'h1, 4'hF, 1'b1, a);
        for (int i = 1; i <= 3; i++) begin
            @(negedge pclk);
            chk("t4_done_timing", done_o, (i == 3));
            chk("t4_no_psel", pselx, 0);
        end
        chk("t4_code", err_code_o, 2'b10);
        drain();

        // partial-strobe write and a one-wait read on slave 1
        waits[1] = 1; sdata[1] = 32'h1234_5678;
        send(8'h7F, 32'h0F0F_0F0F, 4'h5, 1'b1, a);
        send(8'h7C, 32'h0, 4'hF, 1'b0, a);
        drain();
        chk("t4b_rdata", rdata_o, 32'h1234_5678);
        waits[1] = 0;

        // FIFO fill behind a stalled slave 2
        waits[2] = 10; sdata[1] = 32'h0000_5A5A; sdata[2] = 32'h0BAD_CAFE;
        send(8'h84, 32'h0,    4'h0, 1'b0, acc_v[0]);
        send(8'h40, 32'h1111, 4'h3, 1'b1, acc_v[1]);
        send(8'h44, 32'h0,    4'h0, 1'b0, acc_v[2]);
        send(8'h48, 32'h2222, 4'hC, 1'b1, acc_v[3]);
        send(8'h4C, 32'h0,    4'h0, 1'b0, acc_v[4]);
        send(8'h50, 32'h3333, 4'hF, 1'b1, acc_v[5]);
        for (int i = 0; i < 6; i++) chk("t5_accept", acc_v[i], (i < 5));
        drain();
        chk("t5_rdata_last", rdata_o, 32'h0000_5A5A);
        waits[2] = 0;

        // slave error on a read still returns data
        serr[1] = 1'b1; sdata[1] = 32'hCAFE_0001;
        send(8'h60, 32'h0, 4'h0, 1'b0, a);
        drain();
        chk("t6_rdata_slverr", rdata_o, 32'hCAFE_0001);
        serr[1] = 1'b0;

        // reset in the middle of an ACCESS with two requests queued
        waits[2] = 100;
        send(8'h88, 32'h0,  4'h0, 1'b0, a);
        send(8'h44, 32'h77, 4'hF, 1'b1, a);
        send(8'h48, 32'h78, 4'hF, 1'b1, a);
        n = 0;
        while (!penable && n < 50) begin
            @(negedge pclk);
            n++;
        end
        chk("t6_reached_access", penable, 1);
        repeat (3) @(negedge pclk);
        #2 preset_n = 1'b0;
        #1;
        chk("t6_rst_pselx", pselx, 0);
        chk("t6_rst_penable", penable, 0);
        chk("t6_rst_rdy", trans_rdy_o, 1);
        repeat (2) @(negedge pclk);
        #2 preset_n = 1'b1;
        waits[2] = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            chk("t6_flushed_psel", pselx, 0);
            chk("t6_flushed_done", done_o, 0);
        end

        // recovery after reset
        sdata[1] = 32'h600D_F00D;
        send(8'h45, 32'h0000_BEEF, 4'h1, 1'b1, a);
        send(8'h40, 32'h0, 4'h0, 1'b0, a);
        drain();
        chk("t7_rdata", rdata_o, 32'h600D_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
